// File: rtl/host_bus_bridge.sv
// Core-to-host pin bus bridge: one word request is serialised into tagged LANE_W beats,
// each closed by a 4-phase strobe/ack handshake, with optional per-phase timeout.
module host_bus_bridge #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 16,
  parameter int LANE_W   = 8,
  parameter int WAIT_MAX = 255
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_write_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              rsp_valid_o,
  output logic              rsp_err_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic [LANE_W-1:0] pin_out_o,
  output logic              pin_oe_o,
  output logic [1:0]        pin_tag_o,
  output logic              pin_strobe_o,
  input  logic [LANE_W-1:0] pin_in_i,
  input  logic              host_ack_i
);

  localparam int NA  = ADDR_W / LANE_W;
  localparam int ND  = DATA_W / LANE_W;
  localparam int NB  = NA + ND;
  localparam int BW  = $clog2(NB + 1);
  localparam int SW  = ADDR_W + DATA_W;
  localparam int WCW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX + 1) : 1;
  localparam logic [WCW-1:0] WAIT_LAST = (WAIT_MAX > 0) ? WCW'(WAIT_MAX - 1) : '0;

  typedef enum logic [1:0] {S_IDLE, S_STROBE, S_RELEASE} state_t;

  state_t            state_q, state_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic [WCW-1:0]    wait_q, wait_d;
  logic              write_q, write_d;
  logic [SW-1:0]     shift_q, shift_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              ack_m_q, ack_s_q;

  logic wait_hit, last_beat, data_ph, busy;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      beat_q      <= '0;
      wait_q      <= '0;
      write_q     <= 1'b0;
      shift_q     <= '0;
      rdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      ack_m_q     <= 1'b0;
      ack_s_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      wait_q      <= wait_d;
      write_q     <= write_d;
      shift_q     <= shift_d;
      rdata_q     <= rdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      ack_m_q     <= host_ack_i;
      ack_s_q     <= ack_m_q;
    end
  end

  assign wait_hit  = (WAIT_MAX != 0) && (wait_q == WAIT_LAST);
  assign last_beat = (beat_q == BW'(NB - 1));
  assign data_ph   = (beat_q >= BW'(NA));
  assign busy      = (state_q != S_IDLE);

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    wait_d      = wait_q;
    write_d     = write_q;
    shift_d     = shift_q;
    rdata_d     = rdata_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i && req_ready_o) begin
          state_d = S_STROBE;
          beat_d  = '0;
          wait_d  = '0;
          write_d = req_write_i;
          shift_d = {req_wdata_i, req_addr_i};
          rdata_d = '0;
        end
      end
      S_STROBE: begin
        if (ack_s_q) begin
          if (data_ph && !write_q) begin
            for (int k = 0; k < ND; k++) begin
              if (beat_q == BW'(NA + k)) rdata_d[k*LANE_W +: LANE_W] = pin_in_i;
            end
          end
          state_d = S_RELEASE;
          wait_d  = '0;
        end else if (wait_hit) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_RELEASE: begin
        if (!ack_s_q) begin
          wait_d = '0;
          if (last_beat) begin
            state_d     = S_IDLE;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b0;
            rsp_rdata_d = write_q ? '0 : rdata_q;
          end else begin
            state_d = S_STROBE;
            beat_d  = beat_q + 1'b1;
            shift_d = shift_q >> LANE_W;
          end
        end else if (wait_hit) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Held off while the host still asserts ack, e.g. after a RELEASE-phase timeout
  assign req_ready_o  = (state_q == S_IDLE) && !ack_s_q && !reset_i;
  assign pin_strobe_o = (state_q == S_STROBE);
  assign pin_tag_o    = !busy ? 2'b00 : (!data_ph ? 2'b01 : (write_q ? 2'b10 : 2'b11));
  assign pin_oe_o     = busy && (!data_ph || write_q);
  assign pin_out_o    = pin_oe_o ? shift_q[LANE_W-1:0] : '0;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_err_o    = rsp_err_q;
  assign rsp_rdata_o  = rsp_rdata_q;

endmodule

// File: tb/tb_host_bus_bridge.sv
// Directed bench: u0 is 16/16/8 with WAIT_MAX=8, u1 is 12/8/4 without timeout.
module tb_host_bus_bridge;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic rv0, rr0, rw0, rsv0, rse0, oe0, stb0, ack0;
  logic [15:0] ra0, rwd0, rrd0;
  logic [7:0]  po0, pi0;
  logic [1:0]  tag0;

  logic rv1, rr1, rw1, rsv1, rse1, oe1, stb1, ack1;
  logic [7:0]  ra1;
  logic [11:0] rwd1, rrd1;
  logic [3:0]  po1, pi1;
  logic [1:0]  tag1;

  int n_chk = 0;
  int n_bad = 0;

  host_bus_bridge #(.DATA_W(16), .ADDR_W(16), .LANE_W(8), .WAIT_MAX(8)) u0 (
    .clock_i(clk), .reset_i(rst), .req_valid_i(rv0), .req_ready_o(rr0), .req_write_i(rw0),
    .req_addr_i(ra0), .req_wdata_i(rwd0), .rsp_valid_o(rsv0), .rsp_err_o(rse0),
    .rsp_rdata_o(rrd0), .pin_out_o(po0), .pin_oe_o(oe0), .pin_tag_o(tag0),
    .pin_strobe_o(stb0), .pin_in_i(pi0), .host_ack_i(ack0));

  host_bus_bridge #(.DATA_W(12), .ADDR_W(8), .LANE_W(4), .WAIT_MAX(0)) u1 (
    .clock_i(clk), .reset_i(rst), .req_valid_i(rv1), .req_ready_o(rr1), .req_write_i(rw1),
    .req_addr_i(ra1), .req_wdata_i(rwd1), .rsp_valid_o(rsv1), .rsp_err_o(rse1),
    .rsp_rdata_o(rrd1), .pin_out_o(po1), .pin_oe_o(oe1), .pin_tag_o(tag1),
    .pin_strobe_o(stb1), .pin_in_i(pi1), .host_ack_i(ack1));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic f_stb(input int s);       return (s != 0) ? stb1 : stb0; endfunction
  function automatic logic f_oe(input int s);        return (s != 0) ? oe1 : oe0; endfunction
  function automatic logic f_rsv(input int s);       return (s != 0) ? rsv1 : rsv0; endfunction
  function automatic logic f_err(input int s);       return (s != 0) ? rse1 : rse0; endfunction
  function automatic logic [1:0] f_tag(input int s); return (s != 0) ? tag1 : tag0; endfunction
  function automatic logic [7:0] f_out(input int s); return (s != 0) ? {4'h0, po1} : po0; endfunction
  function automatic logic [15:0] f_rd(input int s); return (s != 0) ? {4'h0, rrd1} : rrd0; endfunction

  task automatic set_ack(input int s, input logic v);
    if (s != 0) ack1 = v; else ack0 = v;
  endtask

  task automatic beat(input int s, input logic [1:0] etag, input logic [7:0] eout,
                      input logic eoe, input logic [7:0] rd);
    int n;
    n = 0;
    while (!f_stb(s) && n < 50) begin @(negedge clk); n++; end
    chk("beat_strobe", f_stb(s), 1'b1);
    chk("beat_tag", f_tag(s), etag);
    chk("beat_out", f_out(s), eout);
    chk("beat_oe", f_oe(s), eoe);
    if (s != 0) pi1 = rd[3:0]; else pi0 = rd;
    set_ack(s, 1'b1);
    n = 0;
    while (f_stb(s) && n < 50) begin @(negedge clk); n++; end
    chk("release_strobe", f_stb(s), 1'b0);
    chk("release_tag", f_tag(s), etag);
    set_ack(s, 1'b0);
  endtask

  task automatic wait_rsp(input int s, input logic eerr, input logic [15:0] erd);
    int n;
    n = 0;
    while (!f_rsv(s) && n < 50) begin @(negedge clk); n++; end
    chk("rsp_valid", f_rsv(s), 1'b1);
    chk("rsp_err", f_err(s), eerr);
    chk("rsp_rdata", f_rd(s), erd);
  endtask

  task automatic req0(input logic w, input logic [15:0] a, input logic [15:0] d);
    rv0 = 1'b1; rw0 = w; ra0 = a; rwd0 = d;
    chk("req_ready_idle", rr0, 1'b1);
    @(negedge clk);
    rv0 = 1'b0;
    chk("first_beat_next_cycle", stb0, 1'b1);
  endtask

  initial begin
    int n, nstb;
    rst = 1'b1;
    rv0 = 0; rw0 = 0; ra0 = 0; rwd0 = 0; pi0 = 0; ack0 = 0;
    rv1 = 0; rw1 = 0; ra1 = 0; rwd1 = 0; pi1 = 0; ack1 = 0;
    repeat (3) @(negedge clk);
    chk("rst_ready", rr0, 1'b0);
    chk("rst_strobe", stb0, 1'b0);
    chk("rst_rsp", rsv0, 1'b0);
    chk("rst_tag", tag0, 2'b00);
    rst = 1'b0;
    @(negedge clk);

    // write 0x1234 <- 0xBEEF
    req0(1'b1, 16'h1234, 16'hBEEF);
    beat(0, 2'b01, 8'h34, 1'b1, 8'h00);
    beat(0, 2'b01, 8'h12, 1'b1, 8'h00);
    beat(0, 2'b10, 8'hEF, 1'b1, 8'h00);
    beat(0, 2'b10, 8'hBE, 1'b1, 8'h00);
    wait_rsp(0, 1'b0, 16'h0000);
    @(negedge clk);
    chk("rsp_pulse_one_cycle", rsv0, 1'b0);
    chk("idle_tag", tag0, 2'b00);

    // read 0x00F0, host returns AD then DE
    req0(1'b0, 16'h00F0, 16'h0000);
    beat(0, 2'b01, 8'hF0, 1'b1, 8'h00);
    beat(0, 2'b01, 8'h00, 1'b1, 8'h00);
    beat(0, 2'b11, 8'h00, 1'b0, 8'hAD);
    beat(0, 2'b11, 8'h00, 1'b0, 8'hDE);
    wait_rsp(0, 1'b0, 16'hDEAD);
    @(negedge clk);
    chk("rdata_held", rrd0, 16'hDEAD);

    // no ack on first beat: strobe for 8 cycles then error
    req0(1'b0, 16'h5555, 16'h0000);
    n = 0; nstb = 0;
    while (!rsv0 && n < 40) begin
      if (stb0) nstb++;
      @(negedge clk); n++;
    end
    chk("timeout_strobe_cycles", nstb, 8);
    chk("timeout_strobe_dropped", stb0, 1'b0);
    chk("timeout_rsp", rsv0, 1'b1);
    chk("timeout_err", rse0, 1'b1);
    chk("timeout_rdata", rrd0, 16'h0000);
    @(negedge clk);
    chk("timeout_ready", rr0, 1'b1);
    chk("err_held", rse0, 1'b1);

    // host holds ack: RELEASE times out, ready gated until ack released
    req0(1'b1, 16'h0102, 16'h0304);
    ack0 = 1'b1;
    n = 0;
    while (!rsv0 && n < 40) begin @(negedge clk); n++; end
    chk("hold_ack_rsp", rsv0, 1'b1);
    chk("hold_ack_err", rse0, 1'b1);
    repeat (4) @(negedge clk);
    chk("hold_ack_not_ready", rr0, 1'b0);
    ack0 = 1'b0;
    chk("ack_drop_not_ready_yet", rr0, 1'b0);
    n = 0;
    while (!rr0 && n < 10) begin @(negedge clk); n++; end
    chk("ack_drop_ready", rr0, 1'b1);

    // reset during a read data beat
    req0(1'b0, 16'h4321, 16'h0000);
    beat(0, 2'b01, 8'h21, 1'b1, 8'h00);
    beat(0, 2'b01, 8'h43, 1'b1, 8'h00);
    n = 0;
    while (!stb0 && n < 20) begin @(negedge clk); n++; end
    chk("pre_reset_read_tag", tag0, 2'b11);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_strobe", stb0, 1'b0);
    chk("mid_rst_tag", tag0, 2'b00);
    chk("mid_rst_oe", oe0, 1'b0);
    chk("mid_rst_out", po0, 8'h00);
    chk("mid_rst_rsp", rsv0, 1'b0);
    chk("mid_rst_ready", rr0, 1'b0);
    rst = 1'b0;
    n = 0;
    repeat (3) begin @(negedge clk); if (rsv0) n++; end
    chk("no_rsp_after_rst", n, 0);
    req0(1'b1, 16'hA0B0, 16'hC0D0);
    beat(0, 2'b01, 8'hB0, 1'b1, 8'h00);
    beat(0, 2'b01, 8'hA0, 1'b1, 8'h00);
    beat(0, 2'b10, 8'hD0, 1'b1, 8'h00);
    beat(0, 2'b10, 8'hC0, 1'b1, 8'h00);
    wait_rsp(0, 1'b0, 16'h0000);

    // narrow config: write 0xA5 <- 0x3C7 with req_valid held; read queued behind it
    @(negedge clk);
    rv1 = 1'b1; rw1 = 1'b1; ra1 = 8'hA5; rwd1 = 12'h3C7;
    @(negedge clk);
    rw1 = 1'b0; ra1 = 8'h3C;
    chk("busy_not_ready", rr1, 1'b0);
    beat(1, 2'b01, 8'h5, 1'b1, 8'h0);
    beat(1, 2'b01, 8'hA, 1'b1, 8'h0);
    chk("held_valid_ignored", rr1, 1'b0);
    beat(1, 2'b10, 8'h7, 1'b1, 8'h0);
    beat(1, 2'b10, 8'hC, 1'b1, 8'h0);
    beat(1, 2'b10, 8'h3, 1'b1, 8'h0);
    wait_rsp(1, 1'b0, 16'h0000);
    @(negedge clk);
    rv1 = 1'b0;
    beat(1, 2'b01, 8'hC, 1'b1, 8'h0);
    beat(1, 2'b01, 8'h3, 1'b1, 8'h0);
    beat(1, 2'b11, 8'h0, 1'b0, 8'h1);
    beat(1, 2'b11, 8'h0, 1'b0, 8'h2);
    beat(1, 2'b11, 8'h0, 1'b0, 8'h3);
    wait_rsp(1, 1'b0, 16'h0321);
    @(negedge clk);
    chk("narrow_idle_ready", rr1, 1'b1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
